multicycle_main_controller: RTL and testbench

//  Moore FSM that sequences the shared multicycle MIPS datapath: one ALU, one memory, IR, PC, register file.

---
 rtl/mips_ctrl_pkg.sv | 50 +++++
 rtl/multicycle_main_controller_if.sv | 32 +++
 rtl/ctrl_state_decode.sv | 70 +++++++
 rtl/multicycle_main_controller.sv | 96 +++++++++
 tb/tb_multicycle_main_controller.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS main controller.
// Holds the opcode/funct encodings, the ALU_OP encodings, the state enum and the control-word layout.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] FUNCT_MUL = 6'b011100;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC     = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_MULWAIT  = 4'd12
  } state_t;

  // Raw per-state control word; pc_write/branch are folded into pc_en by the top.
  typedef struct packed {
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_write;
    logic       mul_busy;
  } ctrl_word_t;

endpackage

// File: rtl/multicycle_main_controller_if.sv
// Controller <-> datapath bundle: IR fields and zero flag in, mux selects and write enables out.
// master = controller side, slave = datapath side.
interface multicycle_main_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       iord;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       mem_write;
  logic       illegal_op;
  logic       mul_busy;

  modport master (
    input  opcode, funct, zero,
    output iord, alu_src_a, alu_src_b, alu_op, pc_src, pc_en, ir_write,
           reg_write, reg_dst, mem_to_reg, mem_write, illegal_op, mul_busy
  );

  modport slave (
    output opcode, funct, zero,
    input  iord, alu_src_a, alu_src_b, alu_op, pc_src, pc_en, ir_write,
           reg_write, reg_dst, mem_to_reg, mem_write, illegal_op, mul_busy
  );
endinterface

// File: rtl/ctrl_state_decode.sv
// Combinational state -> control-word table; zero latency, no flow control.
// MULWAIT is only decoded when MUL_STALL_EN is defined, otherwise it falls into the all-zero default.
module ctrl_state_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t cw
);

  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.ir_write  = 1'b1;
        cw.pc_write  = 1'b1;
        cw.alu_src_b = 2'b01;
        cw.alu_op    = ALU_OP_ADD;
      end
      S_DECODE: begin
        cw.alu_src_b = 2'b11;
        cw.alu_op    = ALU_OP_ADD;
      end
      S_MEMADR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = 2'b10;
      end
      S_MEMRD: cw.iord = 1'b1;
      S_MEMWB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        cw.iord      = 1'b1;
        cw.mem_write = 1'b1;
      end
      S_EXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_op    = ALU_OP_FUNCT;
      end
`ifdef MUL_STALL_EN
      S_MULWAIT: begin
        cw.alu_src_a = 1'b1;
        cw.alu_op    = ALU_OP_FUNCT;
        cw.mul_busy  = 1'b1;
      end
`endif
      S_ALUWB: begin
        cw.reg_write = 1'b1;
        cw.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        cw.alu_src_a = 1'b1;
        cw.alu_op    = ALU_OP_SUB;
        cw.pc_src    = 2'b01;
        cw.branch    = 1'b1;
      end
      S_ADDIEXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = 2'b10;
      end
      S_ADDIWB: cw.reg_write = 1'b1;
      S_JUMP: begin
        cw.pc_src   = 2'b10;
        cw.pc_write = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_controller.sv
// Moore FSM sequencing the shared multicycle MIPS datapath; MUL_STALL_EN adds a MULWAIT stall for R-type MUL.
// Latency 2..5 cycles per instruction (MUL 3+MUL_LATENCY with stall); no backpressure, datapath always accepts.
module multicycle_main_controller
  import mips_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  multicycle_main_controller_if.master   ctrl
);

  state_t     state;
  state_t     state_nxt;
  ctrl_word_t cw;
  logic       illegal;

`ifdef MUL_STALL_EN
  localparam logic [3:0] MUL_LOAD = (MUL_LATENCY > 1) ? 4'(MUL_LATENCY - 2) : 4'd0;
  logic [3:0] mul_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_FETCH;
    illegal   = 1'b0;
    case (state)
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        case (ctrl.opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_ADDI:      state_nxt = S_ADDIEXEC;
          OP_J:         state_nxt = S_JUMP;
          default: begin
            state_nxt = S_FETCH;
            illegal   = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_nxt = (ctrl.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nxt = S_MEMWB;
      S_EXEC: begin
`ifdef MUL_STALL_EN
        if (ctrl.funct == FUNCT_MUL && MUL_LATENCY > 1) state_nxt = S_MULWAIT;
        else                                            state_nxt = S_ALUWB;
`else
        state_nxt = S_ALUWB;
`endif
      end
`ifdef MUL_STALL_EN
      S_MULWAIT: state_nxt = (mul_cnt == 4'd0) ? S_ALUWB : S_MULWAIT;
`endif
      S_ADDIEXEC: state_nxt = S_ADDIWB;
      default:    state_nxt = S_FETCH;
    endcase
  end

`ifdef MUL_STALL_EN
  // Counts remaining MULWAIT cycles; loaded on the EXEC -> MULWAIT transition.
  always_ff @(posedge clk) begin
    if (!rst_n)
      mul_cnt <= '0;
    else if (state == S_EXEC && state_nxt == S_MULWAIT)
      mul_cnt <= MUL_LOAD;
    else if (state == S_MULWAIT && mul_cnt != 4'd0)
      mul_cnt <= mul_cnt - 4'd1;
  end
`endif

  ctrl_state_decode u_decode (
    .state (state),
    .cw    (cw)
  );

  // Write enables are squashed during reset so an abandoned instruction never commits.
  assign ctrl.pc_en      = rst_n & (cw.pc_write | (cw.branch & ctrl.zero));
  assign ctrl.ir_write   = rst_n & cw.ir_write;
  assign ctrl.reg_write  = rst_n & cw.reg_write;
  assign ctrl.mem_write  = rst_n & cw.mem_write;
  assign ctrl.iord       = cw.iord;
  assign ctrl.alu_src_a  = cw.alu_src_a;
  assign ctrl.alu_src_b  = cw.alu_src_b;
  assign ctrl.alu_op     = cw.alu_op;
  assign ctrl.pc_src     = cw.pc_src;
  assign ctrl.reg_dst    = cw.reg_dst;
  assign ctrl.mem_to_reg = cw.mem_to_reg;
  assign ctrl.illegal_op = illegal;
  assign ctrl.mul_busy   = cw.mul_busy;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Bench for multicycle_main_controller: instruction-level model checked every cycle plus literal spot checks.
// Honours MUL_STALL_EN for the expected MUL length.
module tb_multicycle_main_controller;

  localparam int MUL_LAT = 4;
`ifdef MUL_STALL_EN
  localparam bit MUL_STALL = 1'b1;
`else
  localparam bit MUL_STALL = 1'b0;
`endif

  typedef struct packed {
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_write;
    logic       illegal_op;
    logic       mul_busy;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_main_controller_if bus ();

  multicycle_main_controller #(.MUL_LATENCY(MUL_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_mode   = 0;
  int   m_step   = 0;
  logic [5:0] m_op = '0;
  logic [5:0] m_fn = '0;
  logic       m_z  = 1'b0;
  obs_t rec [0:31];
  obs_t cmp_act;
  obs_t cmp_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.iord = bus.iord;           o.alu_src_a = bus.alu_src_a;
    o.alu_src_b = bus.alu_src_b; o.alu_op = bus.alu_op;
    o.pc_src = bus.pc_src;       o.pc_en = bus.pc_en;
    o.ir_write = bus.ir_write;   o.reg_write = bus.reg_write;
    o.reg_dst = bus.reg_dst;     o.mem_to_reg = bus.mem_to_reg;
    o.mem_write = bus.mem_write; o.illegal_op = bus.illegal_op;
    o.mul_busy = bus.mul_busy;
    return o;
  endfunction

  function automatic int instr_len(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b100011: return 5;
      6'b101011: return 4;
      6'b000000: return (MUL_STALL && fn == 6'b011100) ? 3 + MUL_LAT : 4;
      6'b001000: return 4;
      6'b000100: return 3;
      6'b000010: return 3;
      default:   return 2;
    endcase
  endfunction

  // Expected outputs at cycle 'step' of an instruction, from the per-instruction cycle tables.
  function automatic obs_t expect_at(input logic [5:0] op, input logic [5:0] fn,
                                     input logic z, input int step);
    obs_t e = '0;
    int   n = instr_len(op, fn);
    if (step == 0) begin
      e.ir_write = 1'b1; e.pc_en = 1'b1; e.alu_src_b = 2'b01;
      return e;
    end
    if (step == 1) begin
      e.alu_src_b = 2'b11; e.illegal_op = (n == 2);
      return e;
    end
    case (op)
      6'b100011: begin
        if (step == 2) begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
        if (step == 3) e.iord = 1'b1;
        if (step == 4) begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
      end
      6'b101011: begin
        if (step == 2) begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
        if (step == 3) begin e.iord = 1'b1; e.mem_write = 1'b1; end
      end
      6'b000000: begin
        if (step == n - 1) begin
          e.reg_write = 1'b1; e.reg_dst = 1'b1;
        end else begin
          e.alu_src_a = 1'b1; e.alu_op = 2'b10; e.mul_busy = (step > 2);
        end
      end
      6'b000100: begin
        e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_en = z;
      end
      6'b001000: begin
        if (step == 2) begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
        if (step == 3) e.reg_write = 1'b1;
      end
      6'b000010: begin
        e.pc_src = 2'b10; e.pc_en = 1'b1;
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    cmp_act = sample();
    if (m_mode == 1) begin
      chk("reset_enables", {28'd0, cmp_act.pc_en, cmp_act.ir_write, cmp_act.reg_write,
                            cmp_act.mem_write}, 32'd0);
    end else if (m_mode == 2) begin
      cmp_exp = expect_at(m_op, m_fn, m_z, m_step);
      if (!rst_n) begin
        cmp_exp.pc_en = 1'b0; cmp_exp.ir_write = 1'b0;
        cmp_exp.reg_write = 1'b0; cmp_exp.mem_write = 1'b0;
      end
      chk($sformatf("model_op%02h_step%0d", m_op, m_step), {16'd0, cmp_act}, {16'd0, cmp_exp});
    end
  end

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int rst_at);
    int n = instr_len(op, fn);
    bus.opcode = op; bus.funct = fn; bus.zero = z;
    m_op = op; m_fn = fn; m_z = z;
    for (int k = 0; k < n; k++) begin
      m_step = k;
      rst_n  = (k != rst_at);
      @(negedge clk);
      rec[k] = sample();
      @(posedge clk);
      #1;
      if (k == rst_at) break;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    int busy_cnt;
    int wb_step;
    rst_n = 1'b0;
    bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0;
    m_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    m_mode = 2;

    // LW
    run_instr(6'b100011, 6'd0, 1'b0, -1);
    chk("fetch_after_reset", {28'd0, rec[0].ir_write, rec[0].pc_en, rec[0].alu_src_b}, 32'hd);
    chk("lw_wb_cycle5", {30'd0, rec[4].reg_write, rec[4].mem_to_reg}, 32'h3);
    chk("lw_no_wb_cycle4", {31'd0, rec[3].reg_write}, 32'h0);

    // R-type ADD
    run_instr(6'b000000, 6'b100000, 1'b0, -1);
    chk("add_exec_aluop", {30'd0, rec[2].alu_op}, 32'h2);
    chk("add_wb_cycle4", {30'd0, rec[3].reg_write, rec[3].reg_dst}, 32'h3);

    // BEQ taken / not taken
    run_instr(6'b000100, 6'd0, 1'b1, -1);
    chk("beq_taken", {29'd0, rec[2].pc_en, rec[2].pc_src}, 32'h5);
    run_instr(6'b000100, 6'd0, 1'b0, -1);
    chk("beq_not_taken", {31'd0, rec[2].pc_en}, 32'h0);

    // Illegal opcode
    run_instr(6'b111111, 6'd0, 1'b0, -1);
    chk("illegal_pulse", {30'd0, rec[0].illegal_op, rec[1].illegal_op}, 32'h1);
    chk("illegal_no_writes", {28'd0, rec[1].pc_en, rec[1].ir_write, rec[1].reg_write,
                              rec[1].mem_write}, 32'h0);

    // MUL
    run_instr(6'b000000, 6'b011100, 1'b0, -1);
    busy_cnt = 0;
    wb_step  = -1;
    for (int k = 0; k < instr_len(6'b000000, 6'b011100); k++) begin
      if (rec[k].mul_busy) busy_cnt++;
      if (rec[k].reg_dst)  wb_step = k;
    end
    chk("mul_busy_cycles", busy_cnt, MUL_STALL ? 32'd3 : 32'd0);
    chk("mul_aluwb_step", wb_step, MUL_STALL ? 32'd6 : 32'd3);

    // SW, ADDI, J
    run_instr(6'b101011, 6'd0, 1'b0, -1);
    chk("sw_memwr", {30'd0, rec[3].iord, rec[3].mem_write}, 32'h3);
    run_instr(6'b001000, 6'd0, 1'b0, -1);
    chk("addi_wb", {30'd0, rec[3].reg_write, rec[3].reg_dst}, 32'h2);
    run_instr(6'b000010, 6'd0, 1'b0, -1);
    chk("j_pc", {29'd0, rec[2].pc_en, rec[2].pc_src}, 32'h6);

    // Reset during MEMWR, then an ADDI must start cleanly from FETCH
    run_instr(6'b101011, 6'd0, 1'b0, 3);
    chk("rst_memwr_no_write", {30'd0, rec[3].iord, rec[3].mem_write}, 32'h2);
    run_instr(6'b001000, 6'd0, 1'b0, -1);
    chk("fetch_after_midreset", {30'd0, rec[0].ir_write, rec[1].ir_write}, 32'h2);

    m_mode = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
